// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: round-robin intersection lights with pedestrian walk and flash mode
module traffic_intersection_ctrl #(
    parameter int NUM_DIR         = 4,
    parameter int TIMER_W         = 8,
    parameter int GREEN_TICKS     = 5,
    parameter int YELLOW_TICKS    = 2,
    parameter int ALL_RED_TICKS   = 1,
    parameter int PED_GREEN_TICKS = 8,
    parameter int FLASH_TICKS     = 1,
    localparam int DIR_W          = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_en,
    input  logic [NUM_DIR-1:0] ped_req,
    input  logic               flash_mode,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] walk,
    output logic [DIR_W-1:0]   active_dir,
    output logic [1:0]         phase
);
    typedef enum logic [1:0] {
        S_ALL_RED = 2'b00,
        S_GREEN   = 2'b01,
        S_YELLOW  = 2'b10,
        S_FLASH   = 2'b11
    } state_t;

    localparam int PED_MAX = (GREEN_TICKS > PED_GREEN_TICKS) ? GREEN_TICKS : PED_GREEN_TICKS;
    localparam logic [TIMER_W-1:0] AR_LAST = TIMER_W'(ALL_RED_TICKS - 1);
    localparam logic [TIMER_W-1:0] G_LAST  = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] PG_LAST = TIMER_W'(PED_MAX - 1);
    localparam logic [TIMER_W-1:0] Y_LAST  = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] F_LAST  = TIMER_W'(FLASH_TICKS - 1);
    localparam logic [DIR_W-1:0]   D_LAST  = DIR_W'(NUM_DIR - 1);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [DIR_W-1:0]     dir_q, dir_d;
    logic [NUM_DIR-1:0]   pend_q, pend_d;
    logic                 walk_q, walk_d;
    logic                 flash_on_q, flash_on_d;
    logic [TIMER_W-1:0]   last;
    logic                 at_end;
    logic [NUM_DIR-1:0]   sel;

    // state register; reset discards pending requests immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ALL_RED;
            timer_q    <= '0;
            dir_q      <= '0;
            pend_q     <= '0;
            walk_q     <= 1'b0;
            flash_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            walk_q     <= walk_d;
            flash_on_q <= flash_on_d;
        end
    end

    // next-state: phase timing, rotation, request latching and flash override
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        walk_d     = walk_q;
        flash_on_d = flash_on_q;
        last       = (state_q == S_ALL_RED) ? AR_LAST :
                     (state_q == S_GREEN)   ? (walk_q ? PG_LAST : G_LAST) :
                     (state_q == S_YELLOW)  ? Y_LAST : F_LAST;
        at_end     = (timer_q == last);
        if (state_q == S_FLASH) begin
            if (!flash_mode) begin
                state_d = S_ALL_RED;
                timer_d = '0;
            end else if (tick_en) begin
                timer_d    = at_end ? '0 : timer_q + 1'b1;
                flash_on_d = at_end ? ~flash_on_q : flash_on_q;
            end
        end else if (flash_mode) begin
            state_d    = S_FLASH;
            timer_d    = '0;
            flash_on_d = 1'b1;
            pend_d     = pend_q | ped_req;
        end else begin
            pend_d = pend_q | ped_req;
            if (tick_en) begin
                timer_d = at_end ? '0 : timer_q + 1'b1;
                if (at_end) begin
                    if (state_q == S_ALL_RED) begin
                        state_d       = S_GREEN;
                        walk_d        = pend_d[dir_q];
                        pend_d[dir_q] = 1'b0;
                    end else if (state_q == S_GREEN) begin
                        state_d = S_YELLOW;
                    end else begin
                        state_d = S_ALL_RED;
                        dir_d   = (dir_q == D_LAST) ? '0 : dir_q + 1'b1;
                    end
                end
            end
        end
    end

    assign sel        = NUM_DIR'(1) << dir_q;
    assign red        = (state_q == S_ALL_RED) ? '1 :
                        (state_q == S_FLASH)   ? '0 : ~sel;
    assign yellow     = (state_q == S_YELLOW) ? sel :
                        (state_q == S_FLASH)  ? {NUM_DIR{flash_on_q}} : '0;
    assign green      = (state_q == S_GREEN) ? sel : '0;
    assign walk       = (state_q == S_GREEN && walk_q) ? sel : '0;
    assign active_dir = dir_q;
    assign phase      = state_q;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: directed scenarios plus random stimulus against a countdown reference model
module tb_traffic_intersection_ctrl;
    localparam int N  = 4;
    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int P  = 8;
    localparam int F  = 1;
    localparam int PG = (G > P) ? G : P;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick_en;
    logic [N-1:0] ped_req;
    logic         flash_mode;
    logic [N-1:0] red, yellow, green, walk;
    logic [1:0]   active_dir;
    logic [1:0]   phase;
    logic [1:0]   red2, yellow2, green2, walk2, ped2;
    logic         active_dir2;
    logic [1:0]   phase2;
    logic         flash2;

    int total = 0;
    int bad   = 0;

    int m_ph, m_left, m_dir, m_fleft;
    bit m_walk, m_fon;
    bit m_pend [N];

    always #5 clk = ~clk;

    traffic_intersection_ctrl dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .ped_req(ped_req), .flash_mode(flash_mode),
        .red(red), .yellow(yellow), .green(green), .walk(walk), .active_dir(active_dir), .phase(phase)
    );

    traffic_intersection_ctrl #(.NUM_DIR(2)) dut2 (
        .clk(clk), .reset(reset), .tick_en(tick_en), .ped_req(ped2), .flash_mode(flash2),
        .red(red2), .yellow(yellow2), .green(green2), .walk(walk2), .active_dir(active_dir2), .phase(phase2)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_left = AR; m_dir = 0; m_walk = 0; m_fon = 0; m_fleft = F;
        for (int d = 0; d < N; d++) m_pend[d] = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_ph == 3) begin
            if (!flash_mode) begin
                m_ph = 0; m_left = AR;
            end else if (tick_en) begin
                m_fleft--;
                if (m_fleft == 0) begin
                    m_fon = !m_fon; m_fleft = F;
                end
            end
        end else begin
            for (int d = 0; d < N; d++) if (ped_req[d]) m_pend[d] = 1;
            if (flash_mode) begin
                m_ph = 3; m_fon = 1; m_fleft = F;
            end else if (tick_en) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_ph == 0) begin
                        m_ph = 1; m_walk = m_pend[m_dir]; m_pend[m_dir] = 0; m_left = m_walk ? PG : G;
                    end else if (m_ph == 1) begin
                        m_ph = 2; m_left = Y;
                    end else begin
                        m_ph = 0; m_dir = (m_dir + 1) % N; m_left = AR;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] er, ey, eg, ew;
        for (int d = 0; d < N; d++) begin
            er[d] = (m_ph == 0) || (m_ph != 3 && d != m_dir);
            ey[d] = (m_ph == 2 && d == m_dir) || (m_ph == 3 && m_fon);
            eg[d] = (m_ph == 1 && d == m_dir);
            ew[d] = (m_ph == 1 && m_walk && d == m_dir);
        end
        chk("red", red, er);
        chk("yellow", yellow, ey);
        chk("green", green, eg);
        chk("walk", walk, ew);
        chk("active_dir", active_dir, m_dir);
        chk("phase", phase, m_ph);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        cyc();
        reset = 1'b0;
    endtask

    task automatic measure(int d, output int len, output int wk);
        int n = 0;
        len = 0;
        wk  = 0;
        while (!green[d] && n < 100) begin
            cyc(); n++;
        end
        chk("measure_wait", n < 100, 1);
        while (green[d] && n < 200) begin
            len++;
            if (walk[d]) wk++;
            cyc(); n++;
        end
    endtask

    initial begin
        int len, wk, n;
        logic [N-1:0] g;
        tick_en = 1'b1; ped_req = '0; flash_mode = 1'b0; ped2 = '0; flash2 = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("reset_red", red, 4'b1111);
        chk("reset2_red", red2, 2'b11);
        repeat (2) cyc();
        reset = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            cyc();
            if (k == 1)  chk("rot_first_green", green, 4'b0001);
            if (k == 1)  chk("rot2_first_green", green2, 2'b01);
            if (k == 6)  chk("rot_yellow0", yellow, 4'b0001);
            if (k == 9)  chk("rot_green1", green, 4'b0010);
            if (k == 9)  chk("rot2_green1", green2, 2'b10);
            if (k == 9)  chk("rot2_dir", active_dir2, 1'b1);
            if (k == 17) chk("rot2_wrap", green2, 2'b01);
            if (k == 17) chk("rot_green2", green, 4'b0100);
            if (k == 33) chk("rot_full", green, 4'b0001);
        end
        ped_req = 4'b0100;
        cyc();
        ped_req = '0;
        measure(2, len, wk);
        chk("ped2_len", len, 8);
        chk("ped2_walk", wk, 8);
        measure(2, len, wk);
        chk("ped2_next_len", len, 5);
        chk("ped2_next_walk", wk, 0);
        ped_req = 4'b0010;
        measure(1, len, wk);
        ped_req = '0;
        chk("hold1_len", len, 8);
        chk("hold1_walk", wk, 8);
        measure(1, len, wk);
        chk("hold1_next_len", len, 8);
        chk("hold1_next_walk", wk, 8);
        n = 0;
        while (!green[1] && n < 100) begin
            cyc(); n++;
        end
        chk("flash_wait", n < 100, 1);
        cyc();
        cyc();
        flash_mode = 1'b1;
        cyc();
        chk("flash_y_on", yellow, 4'b1111);
        chk("flash_red", red, 4'b0000);
        chk("flash_phase", phase, 2'b11);
        cyc();
        chk("flash_y_off", yellow, 4'b0000);
        cyc();
        chk("flash_y_on2", yellow, 4'b1111);
        flash_mode = 1'b0;
        cyc();
        chk("unflash_allred", red, 4'b1111);
        chk("unflash_dir", active_dir, 2'd1);
        measure(1, len, wk);
        chk("unflash_len", len, 5);
        chk("unflash_walk", wk, 0);
        n = 0;
        while (phase != 2'b01 && n < 100) begin
            cyc(); n++;
        end
        tick_en = 1'b0;
        g = green;
        repeat (10) begin
            cyc();
            chk("freeze_green", green, g);
        end
        tick_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick_en = (k % 3 == 0);
            cyc();
        end
        tick_en = 1'b1;
        n = 0;
        while (!green[3] && n < 100) begin
            cyc(); n++;
        end
        ped_req = 4'b0101;
        cyc();
        ped_req = '0;
        n = 0;
        while (!yellow[3] && n < 100) begin
            cyc(); n++;
        end
        chk("rst_wait_y3", yellow[3], 1'b1);
        do_reset();
        chk("midrst_dir", active_dir, 2'd0);
        measure(0, len, wk);
        chk("midrst_len", len, 5);
        chk("midrst_walk", wk, 0);
        for (int k = 0; k < 1500; k++) begin
            tick_en = ($urandom_range(0, 3) != 0);
            ped_req = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 79) == 0) flash_mode = ~flash_mode;
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
